// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// Define APB_TIMEOUT_EN to add an ACCESS-phase watchdog of TIMEOUT_CYCLES stalled cycles.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic                      pready_i,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pslverr_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  winner;
  logic              any_valid;
  logic              grant_fire;
  logic              xfer_done;
  logic              tmo_hit;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;

  logic [ADDR_W-1:0] req_addr  [NUM_REQ];
  logic [DATA_W-1:0] req_wdata [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
      req_wdata[i] = req_wdata_i[i*DATA_W +: DATA_W];
    end
  end

  // Scan from the farthest candidate back to rr_ptr+1 so the nearest valid one wins.
  always_comb begin : pick_winner
    logic [IDX_W:0] cand;
    winner = '0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req_valid_i[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign any_valid  = |req_valid_i;
  assign grant_fire = (state == IDLE) && any_valid;
  assign xfer_done  = (state == ACCESS) && pready_i;

  always_comb begin
    req_ready_o = '0;
    if (grant_fire && reset_n) begin
      req_ready_o = NUM_REQ'(1) << winner;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !pready_i) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // A completing pready_i on the final allowed cycle takes priority over the watchdog.
  assign tmo_hit = (state == ACCESS) && !pready_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    paddr_o   = '0;
    pwdata_o  = '0;
    case (state)
      IDLE: begin
        state_nxt = any_valid ? SETUP : IDLE;
      end
      SETUP: begin
        state_nxt = ACCESS;
        psel_o    = 1'b1;
        pwrite_o  = write_q;
        paddr_o   = addr_q;
        pwdata_o  = wdata_q;
      end
      ACCESS: begin
        state_nxt = (xfer_done || tmo_hit) ? IDLE : ACCESS;
        psel_o    = 1'b1;
        penable_o = 1'b1;
        pwrite_o  = write_q;
        paddr_o   = addr_q;
        pwdata_o  = wdata_q;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write data is stored as zero for reads so pwdata_o never leaks stale requester data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      grant_idx <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
    end else if (grant_fire) begin
      rr_ptr    <= winner;
      grant_idx <= winner;
      addr_q    <= req_addr[winner];
      write_q   <= req_write_i[winner];
      wdata_q   <= req_write_i[winner] ? req_wdata[winner] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (xfer_done) begin
        rsp_valid_o <= NUM_REQ'(1) << grant_idx;
        rsp_rdata_o <= write_q ? '0 : prdata_i;
        rsp_err_o   <= pslverr_i;
      end else if (tmo_hit) begin
        rsp_valid_o <= NUM_REQ'(1) << grant_idx;
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: random and directed traffic against a transaction-timeline model of the arbiter.
// Honors APB_TIMEOUT_EN when the bench is built with it.
module tb_apb_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TMO     = 16;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_write_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_rdata_o;
  logic                      rsp_err_o;
  logic                      psel_o, penable_o, pwrite_o;
  logic [ADDR_W-1:0]         paddr_o;
  logic [DATA_W-1:0]         pwdata_o;
  logic                      pready_i;
  logic [DATA_W-1:0]         prdata_i;
  logic                      pslverr_i;

  always #5 clk = ~clk;

  apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  int check_count = 0;
  int error_count = 0;

  // Requester side: each requester holds at most one outstanding request.
  bit          has_req  [NUM_REQ];
  bit          rq_write [NUM_REQ];
  logic [31:0] rq_addr  [NUM_REQ];
  logic [31:0] rq_wdata [NUM_REQ];

  // Model of the transfer in flight, expressed as a timeline anchored at the grant cycle.
  int          cyc = 0;
  bit          busy;
  int          g_cycle, g_idx, g_waits, g_end;
  bit          g_write, g_err, g_timeout;
  logic [31:0] g_addr, g_wdata, g_rdata;
  int          model_ptr;
  int          rsp_due, rsp_idx;
  logic [31:0] rsp_pend_rdata, exp_rdata;
  bit          rsp_pend_err, exp_err;
  bit          ovr_set, ovr_err;
  int          ovr_waits;
  logic [31:0] ovr_rdata;
  int          grant_log[$];
  int          grant_cyc[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int modelWinner(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic bit anyPending();
    for (int i = 0; i < NUM_REQ; i++) if (has_req[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic postReq(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    has_req[idx]  = 1'b1;
    rq_write[idx] = wr;
    rq_addr[idx]  = addr;
    rq_wdata[idx] = wdata;
  endtask

  task automatic setOverride(input int waits, input logic [31:0] rdata, input bit err);
    ovr_set   = 1'b1;
    ovr_waits = waits;
    ovr_rdata = rdata;
    ovr_err   = err;
  endtask

  task automatic resetModel();
    busy      = 1'b0;
    g_timeout = 1'b0;
    model_ptr = NUM_REQ - 1;
    rsp_due   = -1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    ovr_set   = 1'b0;
  endtask

  // One clock cycle: drive requesters and slave after the edge, check at the negedge, advance model.
  task automatic applyStimulus(input int new_pct, input int max_waits);
    bit                 pready_now;
    int                 grant;
    logic [NUM_REQ-1:0] exp_ready, exp_rspv;
    @(posedge clk);
    #1;
    cyc++;
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!has_req[i] && ($urandom_range(1, 100) <= new_pct)) begin
        postReq(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      req_valid_i[i]                   = has_req[i];
      req_write_i[i]                   = rq_write[i];
      req_addr_i[i*ADDR_W +: ADDR_W]   = rq_addr[i];
      req_wdata_i[i*DATA_W +: DATA_W]  = rq_wdata[i];
    end
    pready_now = busy && !g_timeout && (cyc == g_end);
    pready_i   = pready_now;
    prdata_i   = pready_now ? g_rdata : $urandom;
    pslverr_i  = pready_now ? g_err : 1'($urandom_range(0, 1));

    @(negedge clk);
    grant     = busy ? -1 : modelWinner(req_valid_i, model_ptr);
    exp_ready = '0;
    if (grant >= 0) exp_ready[grant] = 1'b1;
    checkOutput("req_ready", req_ready_o, exp_ready);
    checkOutput("psel", psel_o, busy);
    checkOutput("penable", penable_o, busy && (cyc >= g_cycle + 2));
    checkOutput("paddr", paddr_o, busy ? g_addr : 32'h0);
    checkOutput("pwrite", pwrite_o, busy && g_write);
    checkOutput("pwdata", pwdata_o, (busy && g_write) ? g_wdata : 32'h0);
    exp_rspv = '0;
    if (cyc == rsp_due) begin
      exp_rspv[rsp_idx] = 1'b1;
      exp_rdata         = rsp_pend_rdata;
      exp_err           = rsp_pend_err;
    end
    checkOutput("rsp_valid", rsp_valid_o, exp_rspv);
    checkOutput("rsp_rdata", rsp_rdata_o, exp_rdata);
    checkOutput("rsp_err", rsp_err_o, exp_err);

    if (grant >= 0) begin
      busy          = 1'b1;
      g_cycle       = cyc;
      g_idx         = grant;
      g_addr        = rq_addr[grant];
      g_write       = rq_write[grant];
      g_wdata       = rq_wdata[grant];
      has_req[grant] = 1'b0;
      model_ptr     = grant;
      if (ovr_set) begin
        g_waits = ovr_waits;
        g_rdata = ovr_rdata;
        g_err   = ovr_err;
        ovr_set = 1'b0;
      end else begin
        g_waits = $urandom_range(0, max_waits);
        g_rdata = $urandom;
        g_err   = ($urandom_range(0, 3) == 0);
      end
      g_timeout = 1'b0;
`ifdef APB_TIMEOUT_EN
      g_timeout = (g_waits >= TMO);
`endif
      g_end = g_cycle + 2 + (g_timeout ? TMO - 1 : g_waits);
      grant_log.push_back(grant);
      grant_cyc.push_back(cyc);
    end else if (busy && (cyc == g_end)) begin
      busy           = 1'b0;
      rsp_due        = cyc + 1;
      rsp_idx        = g_idx;
      rsp_pend_rdata = (g_write || g_timeout) ? 32'h0 : g_rdata;
      rsp_pend_err   = g_timeout ? 1'b1 : g_err;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (busy || anyPending() || rsp_due >= cyc); n++) begin
      applyStimulus(0, 3);
    end
  endtask

  task automatic resetMidTransfer();
    postReq(2, 1'b0, 32'h1000_0020, 32'h0);
    setOverride(6, 32'hBAD0_BAD0, 1'b0);
    for (int n = 0; n < 10 && !(busy && cyc >= g_cycle + 3); n++) begin
      applyStimulus(0, 0);
    end
    #2;
    reset_n = 1'b0;
    req_valid_i = 4'b1010;
    #1;
    checkOutput("rst_mid_psel", psel_o, 1'b0);
    checkOutput("rst_mid_penable", penable_o, 1'b0);
    checkOutput("rst_mid_pwrite", pwrite_o, 1'b0);
    checkOutput("rst_mid_paddr", paddr_o, 32'h0);
    checkOutput("rst_mid_ready", req_ready_o, 4'b0000);
    checkOutput("rst_mid_rsp_valid", rsp_valid_o, 4'b0000);
    resetModel();
    pready_i = 1'b0;
    postReq(1, 1'b0, 32'h0000_0104, 32'h0);
    postReq(3, 1'b1, 32'h0000_0300, 32'h3333_0003);
    grant_log.delete();
    grant_cyc.delete();
    drain();
    checkOutput("rst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    checkOutput("rst_second_grant", grant_log.size() > 1 ? grant_log[1] : -1, 3);
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid_i = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    pready_i    = 1'b0;
    prdata_i    = '0;
    pslverr_i   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      postReq(i, 1'b0, 32'h0, 32'h0);
      has_req[i] = 1'b0;
    end
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_psel", psel_o, 1'b0);
    checkOutput("rst_penable", penable_o, 1'b0);
    checkOutput("rst_pwrite", pwrite_o, 1'b0);
    checkOutput("rst_paddr", paddr_o, 32'h0);
    checkOutput("rst_pwdata", pwdata_o, 32'h0);
    checkOutput("rst_ready", req_ready_o, 4'b0000);
    checkOutput("rst_rsp_valid", rsp_valid_o, 4'b0000);
    checkOutput("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    checkOutput("rst_rsp_err", rsp_err_o, 1'b0);

    // All four requesters held valid continuously, zero wait states.
    for (int i = 0; i < NUM_REQ; i++) postReq(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    grant_log.delete();
    grant_cyc.delete();
    repeat (14) applyStimulus(100, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("rr_order", grant_log.size() > i ? grant_log[i] : -1, i % NUM_REQ);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_spacing", grant_cyc.size() > i + 1 ? grant_cyc[i+1] - grant_cyc[i] : -1, 3);
    end
    drain();

    postReq(0, 1'b0, 32'hDEAD_CAFE, 32'h0);
    setOverride(0, 32'h0000_1234, 1'b0);
    drain();

    postReq(2, 1'b1, 32'hDEAD_CAFE, 32'hCAFE_0001);
    setOverride(3, 32'h5A5A_5A5A, 1'b0);
    drain();

    postReq(1, 1'b0, 32'h0000_0040, 32'h0);
    setOverride(0, 32'h7777_0001, 1'b1);
    drain();

`ifdef APB_TIMEOUT_EN
    postReq(0, 1'b0, 32'h0000_0800, 32'h0);
    postReq(1, 1'b0, 32'h0000_0804, 32'h0);
    setOverride(40, 32'hFFFF_0000, 1'b0);
    drain();
`endif

    repeat (500) applyStimulus(30, 3);
    repeat (300) applyStimulus(4, 2);
    drain();

    resetMidTransfer();

    repeat (200) applyStimulus(40, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
